// File: rtl/bus_decoder.sv
// Master-side region decoder and single-outstanding transaction sequencer; m_req to m_ready takes 1 cycle (unmapped), 2+ cycles (mapped) or TIMEOUT+1 cycles (timeout).
// No backpressure on the master: a request is accepted only in IDLE, and m_req is ignored while a transaction is in flight.
module bus_decoder #(
  parameter int ADDR_W     = 32,
  parameter int REGION_LSB = 28,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  output logic              m_ready,
  output logic              m_err,
  output logic [5:0]        bSel,
  output logic              s_req,
  output logic              s_we,
  input  logic [5:0]        s_ready
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      bsel_q, bsel_d;
  logic            s_req_q, s_req_d;
  logic            s_we_q, s_we_d;
  logic            m_ready_q, m_ready_d;
  logic            m_err_q, m_err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [3:0]      region;
  logic            mapped;
  logic            sel_rdy;
  logic            timed_out;

  // Only the region field participates in decoding; the rest of the address goes to the slaves.
  logic            unused_addr;
  assign unused_addr = ^m_addr;

  assign region    = m_addr[REGION_LSB+3:REGION_LSB];
  assign mapped    = (region < 4'd6);
  // bsel_q is one-hot in ACCESS, so this picks out only the selected slave's ready.
  assign sel_rdy   = |(s_ready & bsel_q);
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    bsel_d    = bsel_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    m_ready_d = 1'b0;
    m_err_d   = 1'b0;
    timer_d   = timer_q;

    unique case (state_q)
      IDLE: begin
        if (m_req) begin
          if (mapped) begin
            state_d = ACCESS;
            bsel_d  = 6'b000001 << region[2:0];
            s_req_d = 1'b1;
            s_we_d  = m_we;
            timer_d = '0;
          end else begin
            state_d   = RESP;
            bsel_d    = '0;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
          end
        end
      end

      ACCESS: begin
        // Ready is checked first so a response on the final cycle still completes cleanly.
        if (sel_rdy) begin
          state_d   = RESP;
          s_req_d   = 1'b0;
          m_ready_d = 1'b1;
        end else if (timed_out) begin
          state_d   = RESP;
          s_req_d   = 1'b0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
        bsel_d  = '0;
        s_req_d = 1'b0;
        s_we_d  = 1'b0;
        timer_d = '0;
      end

      default: begin
        state_d = IDLE;
        bsel_d  = '0;
        s_req_d = 1'b0;
        s_we_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bsel_q    <= '0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      bsel_q    <= bsel_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      timer_q   <= timer_d;
    end
  end

  assign bSel    = bsel_q;
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign m_ready = m_ready_q;
  assign m_err   = m_err_q;

  a_onehot_sel: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bSel));
  a_req_has_sel: assert property (@(posedge clk) disable iff (!rst_n) s_req |-> (bSel != 6'b0));
  a_err_qualified: assert property (@(posedge clk) disable iff (!rst_n) m_err |-> m_ready);

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: a transaction-level model fills per-cycle expectations, checked every cycle.
// Waveform history is kept so hand-computed literal expectations can be verified at the end.
module tb_bus_decoder;
  localparam int T = 16;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic        m_ready;
  logic        m_err;
  logic [5:0]  bSel;
  logic        s_req;
  logic        s_we;
  logic [5:0]  s_ready;

  bus_decoder #(.ADDR_W(32), .REGION_LSB(28), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_ready(m_ready), .m_err(m_err), .bSel(bSel), .s_req(s_req), .s_we(s_we),
    .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  bit [5:0] exp_bsel [N];
  bit       exp_sreq [N];
  bit       exp_swe  [N];
  bit       exp_rdy  [N];
  bit       exp_err  [N];
  logic [5:0] h_bsel [N];
  logic       h_sreq [N];
  logic       h_swe  [N];
  logic       h_rdy  [N];
  logic       h_err  [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < N) begin
      h_bsel[cyc] <= bSel;
      h_sreq[cyc] <= s_req;
      h_swe[cyc]  <= s_we;
      h_rdy[cyc]  <= m_ready;
      h_err[cyc]  <= m_err;
      if (check_en && rst_n) begin
        check("bSel", 32'(bSel), 32'(exp_bsel[cyc]));
        check("s_req", 32'(s_req), 32'(exp_sreq[cyc]));
        check("m_ready", 32'(m_ready), 32'(exp_rdy[cyc]));
        check("m_err", 32'(m_err), 32'(exp_err[cyc]));
        if (exp_sreq[cyc]) check("s_we", 32'(s_we), 32'(exp_swe[cyc]));
      end
    end
  end

  // One request issued at the current cycle; ready_at is the ACCESS cycle index at which the
  // selected slave answers (-1 = never). Expectations for the whole transaction are filled up front.
  task automatic do_txn(input logic [31:0] addr, input bit we, input int ready_at,
                        input bit [5:0] other, output int c);
    int region, sel, k, roff;
    bit err, mapped;
    c      = cyc;
    if (c + T + 4 >= N) begin
      $display("FAIL cycle_budget: cycle %0d exceeds table size %0d", c, N);
      $fatal(1);
    end
    region = int'(addr[31:28]);
    mapped = (region < 6);
    sel    = mapped ? region : 0;
    k      = 0;
    if (mapped) begin
      if (ready_at >= 0 && ready_at < T) begin
        k   = ready_at;
        err = 1'b0;
      end else begin
        k   = T - 1;
        err = 1'b1;
      end
      for (int j = 0; j <= k; j++) begin
        exp_bsel[c+1+j] = 6'(1 << sel);
        exp_sreq[c+1+j] = 1'b1;
        exp_swe[c+1+j]  = we;
      end
      roff = k + 2;
      exp_bsel[c+roff] = 6'(1 << sel);
    end else begin
      roff = 1;
      err  = 1'b1;
    end
    exp_rdy[c+roff] = 1'b1;
    exp_err[c+roff] = err;

    m_req   = 1'b1;
    m_addr  = addr;
    m_we    = we;
    s_ready = other;
    for (int i = 1; i <= roff; i++) begin
      @(posedge clk); #1;
      m_addr  = ~addr;
      m_we    = ~we;
      s_ready = other;
      if (mapped && (i - 1) == ready_at) s_ready[sel] = 1'b1;
    end
    @(posedge clk); #1;
    m_req   = 1'b0;
    s_ready = other;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11;
    for (int i = 0; i < N; i++) begin
      exp_bsel[i] = '0; exp_sreq[i] = 0; exp_swe[i] = 0; exp_rdy[i] = 0; exp_err[i] = 0;
    end
    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; s_ready = '0;

    @(negedge clk);
    check("reset_bSel", 32'(bSel), 32'd0);
    check("reset_s_req", 32'(s_req), 32'd0);
    check("reset_s_we", 32'(s_we), 32'd0);
    check("reset_m_ready", 32'(m_ready), 32'd0);
    check("reset_m_err", 32'(m_err), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; check_en = 1'b1;

    do_txn(32'h2000_0010, 1'b0, 0,  6'b000000, c1);
    do_txn(32'h5000_0000, 1'b1, 3,  6'b000000, c2);
    do_txn(32'h7000_0000, 1'b0, 0,  6'b000000, c3);
    do_txn(32'h0000_1234, 1'b0, -1, 6'b111110, c4);
    do_txn(32'h1000_0000, 1'b0, 5,  6'b111101, c5);
    do_txn(32'h1ABC_0000, 1'b1, T-1, 6'b111101, c6);
    do_txn(32'h6000_0000, 1'b1, 0,  6'b000000, c7);
    do_txn(32'hFFFF_FFFF, 1'b0, 0,  6'b000000, c8);
    do_txn(32'h4FFF_FFFC, 1'b1, 2,  6'b101111, c9);
    do_txn(32'h0FFF_FFFF, 1'b0, 1,  6'b000000, c10);

    // Asynchronous reset in the middle of an ACCESS to slave 4.
    check_en = 1'b0;
    m_req = 1'b1; m_addr = 32'h4000_0000; m_we = 1'b1; s_ready = '0;
    @(posedge clk); #1; m_req = 1'b0;
    @(posedge clk); #3;
    check("pre_reset_bSel", 32'(bSel), 32'h10);
    check("pre_reset_s_req", 32'(s_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_bSel", 32'(bSel), 32'd0);
    check("async_s_req", 32'(s_req), 32'd0);
    check("async_s_we", 32'(s_we), 32'd0);
    check("async_m_ready", 32'(m_ready), 32'd0);
    check("async_m_err", 32'(m_err), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; check_en = 1'b1;
    do_txn(32'h3000_0040, 1'b1, 1, 6'b000000, c11);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    check("t1_sel", 32'(h_bsel[c1+1]), 32'h04);
    check("t1_sreq", 32'(h_sreq[c1+1]), 32'd1);
    check("t1_ready", 32'(h_rdy[c1+2]), 32'd1);
    check("t1_err", 32'(h_err[c1+2]), 32'd0);
    check("t1_sel_held", 32'(h_bsel[c1+2]), 32'h04);
    check("t1_idle_sel", 32'(h_bsel[c1+3]), 32'd0);
    check("t2_we", 32'(h_swe[c2+4]), 32'd1);
    check("t2_sel", 32'(h_bsel[c2+4]), 32'h20);
    check("t2_not_early", 32'(h_rdy[c2+4]), 32'd0);
    check("t2_ready", 32'(h_rdy[c2+5]), 32'd1);
    check("t2_err", 32'(h_err[c2+5]), 32'd0);
    check("t3_ready", 32'(h_rdy[c3+1]), 32'd1);
    check("t3_err", 32'(h_err[c3+1]), 32'd1);
    check("t3_sel", 32'(h_bsel[c3+1]), 32'd0);
    check("t3_sreq", 32'(h_sreq[c3+1]), 32'd0);
    check("t4_sreq_last", 32'(h_sreq[c4+16]), 32'd1);
    check("t4_not_early", 32'(h_rdy[c4+16]), 32'd0);
    check("t4_ready", 32'(h_rdy[c4+17]), 32'd1);
    check("t4_err", 32'(h_err[c4+17]), 32'd1);
    check("t4_idle_sel", 32'(h_bsel[c4+18]), 32'd0);
    check("t5_not_early", 32'(h_rdy[c5+6]), 32'd0);
    check("t5_ready", 32'(h_rdy[c5+7]), 32'd1);
    check("t5_err", 32'(h_err[c5+7]), 32'd0);
    check("t5b_ready", 32'(h_rdy[c6+17]), 32'd1);
    check("t5b_err", 32'(h_err[c6+17]), 32'd0);
    check("r6_err", 32'(h_err[c7+1]), 32'd1);
    check("rF_err", 32'(h_err[c8+1]), 32'd1);
    check("s4_sel", 32'(h_bsel[c9+1]), 32'h10);
    check("s0_sel", 32'(h_bsel[c10+1]), 32'h01);
    check("t6_sel", 32'(h_bsel[c11+1]), 32'h08);
    check("t6_ready", 32'(h_rdy[c11+3]), 32'd1);
    check("t6_err", 32'(h_err[c11+3]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
